// File: rtl/stream_utils_pkg.sv
// Shared definitions for the stream_utils blocks: arbiter state encoding and
// an index-width helper that never returns less than one bit.
package stream_utils_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            r = ((32'sd1 <<< i) < n) ? i + 1 : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// scanning upward from ptr_i with wrap-around.
module stream_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    int   pos_s;
    logic hit_s;

    // Priority scan starting at the pointer; the first hit locks out later ones.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        pos_s = 0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s = (int'(ptr_i) + k) % N;
            hit_s = req_i[pos_s] && !any_o;
            idx_o = hit_s ? IDX_W'(pos_s) : idx_o;
            any_o = any_o || hit_s;
        end
    end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Round-robin packet arbiter: shares one registered valid/ready sink among
// N_SOURCES stream masters, holding each grant until the packet's last word.
module stream_packet_arbiter
    import stream_utils_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_SOURCES = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_SOURCES*WIDTH-1:0]        stream_s_data_i,
    input  logic [N_SOURCES-1:0]              stream_s_valid_i,
    input  logic [N_SOURCES-1:0]              stream_s_last_i,
    output logic [N_SOURCES-1:0]              stream_s_ready_o,
    output logic [WIDTH-1:0]                  stream_m_data_o,
    output logic                              stream_m_valid_o,
    output logic                              stream_m_last_o,
    input  logic                              stream_m_ready_i,
    output logic [clog2_min1(N_SOURCES)-1:0]  grant_o,
    output logic                              busy_o
);

    localparam int IDX_W = clog2_min1(N_SOURCES);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [IDX_W-1:0]     pick_s, sel_s;
    logic                 any_s, can_load_s, xfer_s, sel_last_s;
    logic [N_SOURCES-1:0] ready_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == N_SOURCES - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    stream_rr_pick #(
        .N     (N_SOURCES),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (stream_s_valid_i),
        .ptr_i (ptr_q),
        .any_o (any_s),
        .idx_o (pick_s)
    );

    // Ready decode: IDLE offers the picked source, LOCKED only the grantee.
    always_comb begin
        can_load_s = !valid_q || stream_m_ready_i;
        ready_s    = '0;
        sel_s      = grant_q;
        case (state_q)
            ARB_IDLE: begin
                sel_s = pick_s;
                if (any_s && can_load_s) begin
                    ready_s[pick_s] = 1'b1;
                end else begin
                    ready_s = '0;
                end
            end
            ARB_LOCKED: ready_s[grant_q] = can_load_s;
            default:    ready_s = '0;
        endcase
        ready_s = ready_s & {N_SOURCES{rst_n}};
    end

    // Next state: load the output register on a transfer, release on last.
    always_comb begin
        xfer_s     = stream_s_valid_i[sel_s] && ready_s[sel_s];
        sel_last_s = stream_s_last_i[sel_s];
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        data_d     = data_q;
        last_d     = last_q;
        valid_d    = valid_q && !stream_m_ready_i;
        if (xfer_s) begin
            data_d  = stream_s_data_i[int'(sel_s)*WIDTH +: WIDTH];
            last_d  = sel_last_s;
            valid_d = 1'b1;
            grant_d = sel_s;
            state_d = sel_last_s ? ARB_IDLE : ARB_LOCKED;
            ptr_d   = sel_last_s ? next_idx(sel_s) : ptr_q;
        end else begin
            state_d = state_q;
        end
    end

    // State, pointer and output register; all clear on asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign stream_s_ready_o = ready_s;
    assign stream_m_data_o  = data_q;
    assign stream_m_valid_o = valid_q;
    assign stream_m_last_o  = last_q;
    assign grant_o          = grant_q;
    assign busy_o           = (state_q == ARB_LOCKED);

endmodule
